// File: rtl/m_pc_if.sv
// Program-counter control/status bundle: upstream controller drives the master side, m_pc is the slave.
// Carries enable, the clear/load/increment/call/return commands, the next address, and PC/stack status.
interface m_pc_if #(
  parameter int WIDTH = 16,
  parameter int SP_W  = 3
);
  logic             i_en;
  logic             i_clr;
  logic             i_load;
  logic             i_inc;
  logic             i_call;
  logic             i_ret;
  logic [WIDTH-1:0] i_in;
  logic [WIDTH-1:0] o_out;
  logic [SP_W-1:0]  o_sp;
  logic             o_ovf;
  logic             o_unf;

  modport master (
    output i_en, i_clr, i_load, i_inc, i_call, i_ret, i_in,
    input  o_out, o_sp, o_ovf, o_unf
  );

  modport slave (
    input  i_en, i_clr, i_load, i_inc, i_call, i_ret, i_in,
    output o_out, o_sp, o_ovf, o_unf
  );
endinterface

// File: rtl/m_pc.sv
// Program counter (clear > ret > call > load > inc > hold); optional return stack under PC_CALL_STACK_EN.
// One-cycle registered latency; i_en=0 stalls all state, no other backpressure.
module m_pc #(
  parameter int WIDTH       = 16,
  parameter int RESET_VAL   = 0,
  parameter int STACK_DEPTH = 4
) (
  input logic  i_clk,
  input logic  i_rst,
  m_pc_if.slave pc
);
  localparam int              SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] pc_q, pc_d;

  assign pc.o_out = pc_q;

`ifdef PC_CALL_STACK_EN
  localparam int              PTR_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W-1:0] FULL  = SP_W'(STACK_DEPTH);

  logic [WIDTH-1:0] stk [STACK_DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d, top_idx;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, push;

  // wp points at the next free slot; once full it also points at the oldest entry
  assign top_idx = wp_q - PTR_W'(1);

  always_comb begin
    pc_d  = pc_q;
    wp_d  = wp_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (pc.i_clr) begin
      pc_d  = RST_V;
      wp_d  = '0;
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (pc.i_ret) begin
      if (sp_q == '0) begin
        unf_d = 1'b1;
      end else begin
        pc_d = stk[top_idx];
        wp_d = top_idx;
        sp_d = sp_q - SP_W'(1);
      end
    end else if (pc.i_call) begin
      push = 1'b1;
      pc_d = pc.i_in;
      wp_d = wp_q + PTR_W'(1);
      if (sp_q == FULL) ovf_d = 1'b1;
      else              sp_d  = sp_q + SP_W'(1);
    end else if (pc.i_load) begin
      pc_d = pc.i_in;
    end else if (pc.i_inc) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q  <= RST_V;
      wp_q  <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (pc.i_en) begin
      pc_q  <= pc_d;
      wp_q  <= wp_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge i_clk) begin
    if (pc.i_en && push) stk[wp_q] <= pc_q + WIDTH'(1);
  end

  assign pc.o_sp  = sp_q;
  assign pc.o_ovf = ovf_q;
  assign pc.o_unf = unf_q;
`else
  logic unused_stack;
  assign unused_stack = &{1'b0, pc.i_call, pc.i_ret};

  always_comb begin
    pc_d = pc_q;
    if (pc.i_clr)       pc_d = RST_V;
    else if (pc.i_load) pc_d = pc.i_in;
    else if (pc.i_inc)  pc_d = pc_q + WIDTH'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         pc_q <= RST_V;
    else if (pc.i_en)  pc_q <= pc_d;
  end

  assign pc.o_sp  = '0;
  assign pc.o_ovf = 1'b0;
  assign pc.o_unf = 1'b0;
`endif
endmodule
